// File: rtl/dep_issue_sched_if.sv
// Scheduler handshake bundle: allocation, completion and issue signals.
interface dep_issue_sched_if #(
  parameter int unsigned BS = 16
);
  localparam int unsigned IW = $clog2(BS);

  logic          alloc_valid;
  logic [IW-1:0] alloc_index;
  logic [BS-1:0] alloc_dep;
  logic          cmpl_valid;
  logic [IW-1:0] cmpl_index;
  logic          issue_ready;
  logic          issue_valid;
  logic [IW-1:0] issue_index;
  logic [BS-1:0] busy;
  logic          full;
  logic          err;

  modport master (
    output alloc_valid, alloc_index, alloc_dep, cmpl_valid, cmpl_index, issue_ready,
    input  issue_valid, issue_index, busy, full, err
  );

  modport slave (
    input  alloc_valid, alloc_index, alloc_dep, cmpl_valid, cmpl_index, issue_ready,
    output issue_valid, issue_index, busy, full, err
  );
endinterface

// File: rtl/dep_issue_sched.sv
// Dependency-tracking issue scheduler with a registered single-grant offer stage.
// DEP_ISSUE_SCHED_RR_EN selects round-robin grant; default is lowest-index priority.
module dep_issue_sched #(
  parameter int unsigned BS = 16
) (
  input  logic             clk,
  input  logic             rst,
  dep_issue_sched_if.slave sif
);
  localparam int unsigned IW = $clog2(BS);

  typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY, S_ISSUED} slot_state_t;
  typedef enum logic {G_IDLE, G_OFFER} grant_state_t;

  slot_state_t   slot_q [BS];
  slot_state_t   slot_d [BS];
  logic [BS-1:0] row_q  [BS];
  logic [BS-1:0] row_d  [BS];
  logic [BS-1:0] busy_q, busy_d;
  logic          full_q, err_q, err_d;

  grant_state_t  gstate_q;
  logic          issue_valid_q;
  logic [IW-1:0] issue_index_q;

  logic [BS-1:0] free_vec, ready_vec, cmpl_mask, cmpl_col, alloc_row;
  logic          hs, cmpl_ok, alloc_free, alloc_ok, any_ready;
  logic [IW-1:0] sel;

  // Slot bookkeeping: completion is applied before allocation on the same slot.
  always_comb begin
    for (int i = 0; i < BS; i++) begin
      free_vec[i]  = (slot_q[i] == S_FREE);
      ready_vec[i] = (slot_q[i] == S_READY);
    end
    hs         = issue_valid_q & sif.issue_ready;
    cmpl_ok    = sif.cmpl_valid && (slot_q[sif.cmpl_index] == S_ISSUED);
    cmpl_col   = BS'(1) << sif.cmpl_index;
    cmpl_mask  = sif.cmpl_valid ? cmpl_col : '0;
    alloc_free = (slot_q[sif.alloc_index] == S_FREE) ||
                 (cmpl_ok && (sif.cmpl_index == sif.alloc_index));
    alloc_ok   = sif.alloc_valid && alloc_free;
    alloc_row  = sif.alloc_dep & ~(BS'(1) << sif.alloc_index) & ~free_vec & ~cmpl_mask;
    err_d      = err_q | (sif.alloc_valid & ~alloc_free) | (sif.cmpl_valid & ~cmpl_ok);

    for (int i = 0; i < BS; i++) begin
      slot_d[i] = slot_q[i];
      row_d[i]  = row_q[i];
      if (cmpl_ok) row_d[i] = row_q[i] & ~cmpl_col;
      if (slot_q[i] == S_WAIT && row_q[i] == '0) slot_d[i] = S_READY;
      if (hs && issue_index_q == IW'(i)) slot_d[i] = S_ISSUED;
      if (cmpl_ok && sif.cmpl_index == IW'(i)) begin
        slot_d[i] = S_FREE;
        row_d[i]  = '0;
      end
      if (alloc_ok && sif.alloc_index == IW'(i)) begin
        row_d[i]  = alloc_row;
        slot_d[i] = (alloc_row != '0) ? S_WAIT : S_READY;
      end
      busy_d[i] = (slot_d[i] != S_FREE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BS; i++) begin
        slot_q[i] <= S_FREE;
        row_q[i]  <= '0;
      end
      busy_q <= '0;
      full_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < BS; i++) begin
        slot_q[i] <= slot_d[i];
        row_q[i]  <= row_d[i];
      end
      busy_q <= busy_d;
      full_q <= &busy_d;
      err_q  <= err_d;
    end
  end

`ifdef DEP_ISSUE_SCHED_RR_EN
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] rr_idx;

  // Descending scan so the nearest READY slot at or after the pointer wins.
  always_comb begin
    sel    = '0;
    rr_idx = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      rr_idx = rr_ptr_q + IW'(i);
      if (ready_vec[rr_idx]) sel = rr_idx;
    end
    any_ready = |ready_vec;
  end
`else
  always_comb begin
    sel = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      if (ready_vec[i]) sel = IW'(i);
    end
    any_ready = |ready_vec;
  end
`endif

  // Grant FSM: latch one READY slot, hold it until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gstate_q      <= G_IDLE;
      issue_valid_q <= 1'b0;
      issue_index_q <= '0;
`ifdef DEP_ISSUE_SCHED_RR_EN
      rr_ptr_q      <= '0;
`endif
    end else begin
      case (gstate_q)
        G_IDLE: begin
          if (any_ready) begin
            gstate_q      <= G_OFFER;
            issue_valid_q <= 1'b1;
            issue_index_q <= sel;
          end
        end
        G_OFFER: begin
          if (sif.issue_ready) begin
            gstate_q      <= G_IDLE;
            issue_valid_q <= 1'b0;
`ifdef DEP_ISSUE_SCHED_RR_EN
            rr_ptr_q      <= issue_index_q + IW'(1);
`endif
          end
        end
        default: begin
          gstate_q      <= G_IDLE;
          issue_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign sif.issue_valid = issue_valid_q;
  assign sif.issue_index = issue_index_q;
  assign sif.busy        = busy_q;
  assign sif.full        = full_q;
  assign sif.err         = err_q;
endmodule

// File: tb/tb_dep_issue_sched.sv
// Directed bench for dep_issue_sched with hand-computed expectations (BS=16).
module tb_dep_issue_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  dep_issue_sched_if #(.BS(16)) bus();
  dep_issue_sched #(.BS(16)) dut (.clk(clk), .rst(rst), .sif(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.alloc_valid = 1'b0;
    bus.alloc_index = '0;
    bus.alloc_dep   = '0;
    bus.cmpl_valid  = 1'b0;
    bus.cmpl_index  = '0;
    bus.issue_ready = 1'b0;
  endtask

  task automatic set_alloc(input int idx, input logic [15:0] dep);
    bus.alloc_valid = 1'b1;
    bus.alloc_index = 4'(idx);
    bus.alloc_dep   = dep;
  endtask

  task automatic set_cmpl(input int idx);
    bus.cmpl_valid = 1'b1;
    bus.cmpl_index = 4'(idx);
  endtask

  task automatic handshake();
    bus.issue_ready = 1'b1;
    step();
    bus.issue_ready = 1'b0;
  endtask

  int grants [3];

  initial begin
    clear_in();
`ifdef DEP_ISSUE_SCHED_RR_EN
    grants = '{4, 0, 1};
`else
    grants = '{0, 1, 4};
`endif
    #1 rst = 1'b1;
    #1;
    check("rst_valid", 32'(bus.issue_valid), 32'd0);
    check("rst_index", 32'(bus.issue_index), 32'd0);
    check("rst_busy",  32'(bus.busy), 32'h0);
    check("rst_full",  32'(bus.full), 32'd0);
    check("rst_err",   32'(bus.err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step();

    // Independent instruction: READY after one edge, offered after two.
    set_alloc(3, 16'h0000);
    step(); clear_in();
    check("s1_busy", 32'(bus.busy), 32'h0008);
    check("s1_noval", 32'(bus.issue_valid), 32'd0);
    step();
    check("s1_valid", 32'(bus.issue_valid), 32'd1);
    check("s1_index", 32'(bus.issue_index), 32'd3);
    handshake();
    check("s1_done", 32'(bus.issue_valid), 32'd0);

    // Slot 5 waits on issued slot 3, wakes one edge after the completion edge.
    set_alloc(5, 16'h0008);
    step(); clear_in();
    check("s2_busy", 32'(bus.busy), 32'h0028);
    step(); step();
    check("s2_wait", 32'(bus.issue_valid), 32'd0);
    set_cmpl(3);
    step(); clear_in();
    check("s2_busy3", 32'(bus.busy), 32'h0020);
    check("s2_err", 32'(bus.err), 32'd0);
    step();
    check("s2_lat", 32'(bus.issue_valid), 32'd0);
    step();
    check("s2_valid", 32'(bus.issue_valid), 32'd1);
    check("s2_index", 32'(bus.issue_index), 32'd5);
    handshake();

    // Self bit and completing bit are both masked: straight to READY.
    set_alloc(2, 16'h0024);
    set_cmpl(5);
    step(); clear_in();
    check("s3_busy", 32'(bus.busy), 32'h0004);
    check("s3_err", 32'(bus.err), 32'd0);
    step();
    check("s3_valid", 32'(bus.issue_valid), 32'd1);
    check("s3_index", 32'(bus.issue_index), 32'd2);
    handshake();
    set_cmpl(2);
    step(); clear_in();
    check("s3_empty", 32'(bus.busy), 32'h0);

    // Held offer stays stable; grant order after release depends on policy.
    set_alloc(1, 16'h0000);
    step();
    set_alloc(4, 16'h0000);
    step();
    check("s4_valid", 32'(bus.issue_valid), 32'd1);
    check("s4_index", 32'(bus.issue_index), 32'd1);
    set_alloc(0, 16'h0000);
    step(); clear_in();
    check("s4_busy", 32'(bus.busy), 32'h0013);
    for (int i = 0; i < 5; i++) begin
      step();
      check("s4_hold_v", 32'(bus.issue_valid), 32'd1);
      check("s4_hold_i", 32'(bus.issue_index), 32'd1);
    end
    handshake();
    check("s4_hs", 32'(bus.issue_valid), 32'd0);
    set_cmpl(1);
    set_alloc(1, 16'h0000);
    step(); clear_in();
    check("s4_realloc_err", 32'(bus.err), 32'd0);
    check("s4_realloc_busy", 32'(bus.busy), 32'h0013);
    for (int k = 0; k < 3; k++) begin
      check("s4_gv", 32'(bus.issue_valid), 32'd1);
      check("s4_gi", 32'(bus.issue_index), 32'(grants[k]));
      handshake();
      check("s4_gdone", 32'(bus.issue_valid), 32'd0);
      step();
    end
    set_cmpl(0); step();
    set_cmpl(1); step();
    set_cmpl(4); step(); clear_in();
    check("s4_drain", 32'(bus.busy), 32'h0);
    check("s4_err", 32'(bus.err), 32'd0);

    // Fill every slot; slot 9 waits on slot 8.
    for (int i = 0; i < 16; i++) begin
      set_alloc(i, (i == 9) ? 16'h0100 : 16'h0000);
      step();
    end
    clear_in();
    check("s5_busy", 32'(bus.busy), 32'hFFFF);
    check("s5_full", 32'(bus.full), 32'd1);
    check("s5_err0", 32'(bus.err), 32'd0);
    check("s5_valid", 32'(bus.issue_valid), 32'd1);
    check("s5_index", 32'(bus.issue_index), 32'd0);
    set_alloc(7, 16'h0000);
    step(); clear_in();
    check("s5_err1", 32'(bus.err), 32'd1);
    check("s5_busy1", 32'(bus.busy), 32'hFFFF);
    set_cmpl(9);
    step(); clear_in();
    check("s5_err2", 32'(bus.err), 32'd1);
    check("s5_busy2", 32'(bus.busy), 32'hFFFF);
    check("s5_full2", 32'(bus.full), 32'd1);
    step();
    check("s5_w9", 32'(bus.busy[9]), 32'd1);

    // Reset mid-offer clears everything before the next edge.
    #2 rst = 1'b1;
    #1;
    check("s6_valid", 32'(bus.issue_valid), 32'd0);
    check("s6_index", 32'(bus.issue_index), 32'd0);
    check("s6_busy",  32'(bus.busy), 32'h0);
    check("s6_full",  32'(bus.full), 32'd0);
    check("s6_err",   32'(bus.err), 32'd0);
    @(negedge clk) rst = 1'b0;
    step(); step();
    check("s6_idle", 32'(bus.issue_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dep_issue_sched.md
DEP_ISSUE_SCHED -- requirements
Module: dep_issue_sched

Interface
REQ-001 SHALL have parameter BS, default 16, meaning the number of instruction buffer slots (power of two, >= 2).
REQ-002 SHALL have port clk, input, 1, clock, rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port alloc_valid, input, 1, meaning a new instruction is written into slot alloc_index this cycle.
REQ-005 SHALL have port alloc_index, input, clog2(BS), meaning the target slot of the allocation.
REQ-006 SHALL have port alloc_dep, input, BS, meaning the dependency vector of the new instruction, with bit k set when it depends on slot k.
REQ-007 SHALL have port cmpl_valid, input, 1, meaning the instruction in slot cmpl_index finished writeback.
REQ-008 SHALL have port cmpl_index, input, clog2(BS), meaning the completing slot.
REQ-009 SHALL have port issue_ready, input, 1, meaning the downstream execute stage accepts an issue.
REQ-010 SHALL have port issue_valid, output, 1, meaning a granted slot is offered for issue.
REQ-011 SHALL have port issue_index, output, clog2(BS), meaning the granted slot.
REQ-012 SHALL have port busy, output, BS, meaning bit k is set when slot k is not FREE.
REQ-013 SHALL have port full, output, 1, meaning all BS slots are busy.
REQ-014 SHALL have port err, output, 1, a sticky protocol-violation flag.

Function
REQ-015 SHALL hold per-slot state FREE, WAIT, READY or ISSUED, plus a BS-bit pending-dependency row per slot.
REQ-016 SHALL, on alloc_valid to a FREE slot, store as the row alloc_dep masked by: the self bit cleared, FREE slots cleared, and the cmpl_index bit cleared when cmpl_valid is high in the same cycle.
REQ-017 SHALL place the allocated slot in WAIT if the masked row is nonzero, otherwise in READY, at the next edge.
REQ-018 SHALL, on cmpl_valid to an ISSUED slot, set that slot to FREE and clear column cmpl_index in every row at the next edge.
REQ-019 SHALL move a WAIT slot to READY on the edge after its row becomes zero, giving one cycle of wakeup latency from completion to READY.
REQ-020 SHALL, when alloc_valid and cmpl_valid target the same slot in one cycle, apply completion first, so an ISSUED slot is freed and reallocated in that cycle.
REQ-021 SHALL ignore an allocation to a non-FREE slot (after applying REQ-020) and set err.
REQ-022 SHALL ignore a completion to a slot that is not ISSUED and set err.
REQ-023 SHALL implement the grant register as a two-state FSM, IDLE or OFFER; in IDLE with any READY slot it selects one slot per REQ-032, latches it into issue_index, and enters OFFER at the next edge.
REQ-024 SHALL drive issue_valid high only in OFFER, and SHALL hold issue_index stable until the handshake (issue_valid and issue_ready both high).
REQ-025 SHALL, on handshake, set the granted slot to ISSUED and return to IDLE at the next edge, with at most one issue per two cycles.
REQ-026 SHALL drive busy, full and issue outputs from registers only, with no combinational path from inputs.

Reset
REQ-027 SHALL, while rst is high, set every slot to FREE, every row to 0, the FSM to IDLE, issue_valid to 0, issue_index to 0, busy to 0, full to 0 and err to 0.
REQ-028 SHALL, on reset asserted mid-offer, drop issue_valid immediately (asynchronously) and discard the grant.
REQ-029 SHALL clear err only by reset.

Configuration
REQ-030 SHALL use macro DEP_ISSUE_SCHED_RR_EN to select the grant policy.
REQ-031 SHALL, with DEP_ISSUE_SCHED_RR_EN defined, grant the first READY slot at or after a rotating pointer, wrapping from BS-1 to 0; the pointer resets to 0 and moves to granted index + 1 (mod BS) on each handshake.
REQ-032 SHALL, without DEP_ISSUE_SCHED_RR_EN, grant the lowest-index READY slot (fixed priority).

Verification
REQ-033 SHALL pass this scenario: alloc slot 3 with dep 0 -> READY at edge+1, issue_valid=1 with issue_index=3 at edge+2, and with issue_ready=1 the slot becomes ISSUED.
REQ-034 SHALL pass this scenario: alloc slot 5 with dep 0x0008 while slot 3 is ISSUED, then cmpl slot 3 -> slot 5 is READY one edge after completion and busy[3]=0.
REQ-035 SHALL pass this scenario: alloc slot 2 with dep 0x0024 in the same cycle as cmpl slot 5, with slot 5 ISSUED and slot 2 FREE -> slot 2 goes directly to READY, since both its self bit and the completing bit are masked.
REQ-036 SHALL pass this scenario: fill all 16 slots -> full=1; alloc slot 7 again -> ignored and err=1; cmpl slot 9 while slot 9 is in WAIT -> err stays 1 and slot 9 is unchanged.
REQ-037 SHALL pass this scenario: slots 1 and 4 READY with issue_ready held 0 for 5 cycles -> issue_index stays constant at 1 (fixed priority) throughout, and in RR mode after 1 issues, 4 is granted next before a re-allocated slot 1.
REQ-038 SHALL pass this scenario: assert rst during OFFER -> issue_valid=0 immediately, and all outputs equal their reset values before the next edge.
